// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding decode.
// Owns the architectural PC, drives the instruction-memory request/address with a
// ready handshake, applies execute redirects and hazard-unit stall/flush, and holds the
// fetch/decode pipeline register (inst_d / pc_d / valid_d, pc_d = fetch address + 8).
// Optional instruction/bubble counters are built when FETCH_PERF_CNT_EN is defined;
// otherwise fetch_cnt and bubble_cnt are tied to zero.
module fetch_stage #(
    parameter int unsigned N        = 32,
    parameter logic [N-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [N-1:0] NOP_INST = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_f,
    input  logic         stall_d,
    input  logic         flush_d,
    input  logic         pc_src,
    input  logic [N-1:0] branch_target,
    output logic [N-1:0] imem_addr,
    output logic         imem_req,
    input  logic [N-1:0] imem_rdata,
    input  logic         imem_ready,
    output logic [N-1:0] inst_d,
    output logic [N-1:0] pc_d,
    output logic         valid_d,
    output logic [31:0]  fetch_cnt,
    output logic [31:0]  bubble_cnt
);

    // Fetch FSM encoding
    localparam logic [1:0] ST_FETCH      = 2'd0;
    localparam logic [1:0] ST_WAIT       = 2'd1;
    localparam logic [1:0] ST_WAIT_REDIR = 2'd2;

    localparam logic [N-1:0] PC_STEP    = N'(4);
    // Decode sees the R15-read value: fetch address + 8
    localparam logic [N-1:0] PC_READ_OFS = N'(8);

    logic [1:0]   state_q, state_d;
    logic [N-1:0] pc_f_q, pc_f_d;
    logic [N-1:0] pending_q, pending_d;

    logic [N-1:0] fd_inst_q, fd_inst_d;
    logic [N-1:0] fd_pc_q, fd_pc_d;
    logic         fd_valid_q, fd_valid_d;

    logic word_valid;
    logic discard;
    logic fetch_ok;

    // Memory handshake: a request is always outstanding out of reset
    always_comb begin
        imem_req  = ~rst;
        imem_addr = pc_f_q;
    end

    // Classify this cycle's returned word
    always_comb begin
        word_valid = imem_req & imem_ready;
        // The word answering a fetch made before a redirect is stale
        discard    = (state_q == ST_WAIT_REDIR);
        fetch_ok   = word_valid & ~discard & ~stall_f;
    end

    // Next-PC and FSM: memory-wait hold > pc_src > stall_f > sequential
    always_comb begin
        state_d   = state_q;
        pc_f_d    = pc_f_q;
        pending_d = pending_q;
        case (state_q)
            ST_WAIT_REDIR: begin
                // Last redirect wins while the stale word is still outstanding
                if (pc_src) begin
                    pending_d = branch_target;
                end
                if (word_valid) begin
                    pc_f_d    = pc_src ? branch_target : pending_q;
                    pending_d = '0;
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                // ST_FETCH and ST_WAIT behave identically once data arrives
                if (!word_valid) begin
                    if (pc_src) begin
                        pending_d = branch_target;
                        state_d   = ST_WAIT_REDIR;
                    end else begin
                        state_d   = ST_WAIT;
                    end
                end else begin
                    state_d = ST_FETCH;
                    if (pc_src) begin
                        pc_f_d = branch_target;
                    end else if (!stall_f) begin
                        pc_f_d = pc_f_q + PC_STEP;
                    end
                end
            end
        endcase
    end

    // F/D register next state: flush/redirect > stall_d > load (word or bubble)
    always_comb begin
        fd_inst_d  = fd_inst_q;
        fd_pc_d    = fd_pc_q;
        fd_valid_d = fd_valid_q;
        if (flush_d || pc_src) begin
            fd_inst_d  = NOP_INST;
            fd_pc_d    = '0;
            fd_valid_d = 1'b0;
        end else if (stall_d) begin
            // hold all three outputs
        end else if (fetch_ok) begin
            fd_inst_d  = imem_rdata;
            fd_pc_d    = pc_f_q + PC_READ_OFS;
            fd_valid_d = 1'b1;
        end else begin
            fd_inst_d  = NOP_INST;
            fd_pc_d    = '0;
            fd_valid_d = 1'b0;
        end
    end

    // PC, FSM and pending redirect state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_f_q    <= RESET_PC;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_f_q    <= pc_f_d;
            pending_q <= pending_d;
        end
    end

    // Fetch/decode pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fd_inst_q  <= NOP_INST;
            fd_pc_q    <= '0;
            fd_valid_q <= 1'b0;
        end else begin
            fd_inst_q  <= fd_inst_d;
            fd_pc_q    <= fd_pc_d;
            fd_valid_q <= fd_valid_d;
        end
    end

    // Decode-facing outputs come straight from the F/D register
    always_comb begin
        inst_d  = fd_inst_q;
        pc_d    = fd_pc_q;
        valid_d = fd_valid_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic        fd_load;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Count F/D loads only; stall_d holds are neither fetches nor bubbles
    always_comb begin
        fd_load      = flush_d | pc_src | ~stall_d;
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (fd_load) begin
            if (fd_valid_d) begin
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end else begin
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
        end
    end

    // Performance counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Counter outputs
    always_comb begin
        fetch_cnt  = fetch_cnt_q;
        bubble_cnt = bubble_cnt_q;
    end
`else
    // Counters not built
    always_comb begin
        fetch_cnt  = '0;
        bubble_cnt = '0;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// Memory model returns 0xE000_0001 + addr/4; NOP_INST is overridden so bubbles are
// distinguishable from a zero word.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hE320_F000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f, stall_d, flush_d, pc_src;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] inst_d, pc_d;
    logic        valid_d;
    logic [31:0] fetch_cnt, bubble_cnt;

    int n_total = 0;
    int n_pass  = 0;

    fetch_stage #(
        .N        (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .inst_d        (inst_d),
        .pc_d          (pc_d),
        .valid_d       (valid_d),
        .fetch_cnt     (fetch_cnt),
        .bubble_cnt    (bubble_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory model
    always_comb imem_rdata = 32'hE000_0001 + (imem_addr >> 2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_fd(input string tag, input logic [31:0] e_inst, input logic [31:0] e_pc,
                          input logic e_valid, input logic [31:0] e_addr);
        chk({tag, ".inst_d"}, inst_d, e_inst);
        chk({tag, ".pc_d"}, pc_d, e_pc);
        chk({tag, ".valid_d"}, {31'b0, valid_d}, {31'b0, e_valid});
        chk({tag, ".imem_addr"}, imem_addr, e_addr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src = 0;
        branch_target = '0; imem_ready = 1'b1;
        #1;
        chk("rst.req", {31'b0, imem_req}, 32'd0);
        chk_fd("rst", NOP, 32'h0, 1'b0, 32'h0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("run.req", {31'b0, imem_req}, 32'd1);
        chk("rst.fetch_cnt", fetch_cnt, 32'd0);

        // 1: zero-wait sequential fetch
        step(); chk_fd("t1a", 32'hE000_0001, 32'h08, 1'b1, 32'h04);
        `ifdef FETCH_PERF_CNT_EN
        chk("t1.fetch_cnt", fetch_cnt, 32'd1);
        `endif
        step(); chk_fd("t1b", 32'hE000_0002, 32'h0C, 1'b1, 32'h08);
        step(); chk_fd("t1c", 32'hE000_0003, 32'h10, 1'b1, 32'h0C);
        step(); chk_fd("t1d", 32'hE000_0004, 32'h14, 1'b1, 32'h10);

        // 2: three wait cycles at 0x10
        imem_ready = 1'b0;
        step(); chk_fd("t2w1", NOP, 32'h0, 1'b0, 32'h10);
        step(); chk_fd("t2w2", NOP, 32'h0, 1'b0, 32'h10);
        step(); chk_fd("t2w3", NOP, 32'h0, 1'b0, 32'h10);
        imem_ready = 1'b1;
        step(); chk_fd("t2r", 32'hE000_0005, 32'h18, 1'b1, 32'h14);
        step(); step(); step();
        chk_fd("t2seq", 32'hE000_0008, 32'h24, 1'b1, 32'h20);

        // 3: branch at pc_f=0x20 to 0x100
        pc_src = 1'b1; branch_target = 32'h100;
        step(); chk_fd("t3br", NOP, 32'h0, 1'b0, 32'h100);
        pc_src = 1'b0;
        step(); chk_fd("t3tgt", 32'hE000_0041, 32'h108, 1'b1, 32'h104);

        // 4: redirect arriving while waiting at 0x30
        pc_src = 1'b1; branch_target = 32'h30;
        step(); chk_fd("t4br", NOP, 32'h0, 1'b0, 32'h30);
        pc_src = 1'b0; imem_ready = 1'b0;
        step(); chk_fd("t4wait", NOP, 32'h0, 1'b0, 32'h30);
        pc_src = 1'b1; branch_target = 32'h200;
        step(); chk_fd("t4redir", NOP, 32'h0, 1'b0, 32'h30);
        pc_src = 1'b0;
        step(); chk_fd("t4hold", NOP, 32'h0, 1'b0, 32'h30);
        imem_ready = 1'b1;
        step(); chk_fd("t4disc", NOP, 32'h0, 1'b0, 32'h200);
        step(); chk_fd("t4tgt", 32'hE000_0081, 32'h208, 1'b1, 32'h204);

        // 5: stalls and flush around 0x40
        pc_src = 1'b1; branch_target = 32'h3C;
        step(); chk_fd("t5br", NOP, 32'h0, 1'b0, 32'h3C);
        pc_src = 1'b0;
        step(); chk_fd("t5ld", 32'hE000_0010, 32'h44, 1'b1, 32'h40);
        stall_f = 1'b1; stall_d = 1'b1;
        step(); chk_fd("t5st1", 32'hE000_0010, 32'h44, 1'b1, 32'h40);
        step(); chk_fd("t5st2", 32'hE000_0010, 32'h44, 1'b1, 32'h40);
        stall_f = 1'b0; stall_d = 1'b0;
        step(); chk_fd("t5go", 32'hE000_0011, 32'h48, 1'b1, 32'h44);
        stall_f = 1'b1;
        step(); chk_fd("t5sf", NOP, 32'h0, 1'b0, 32'h44);
        stall_f = 1'b0;
        step(); chk_fd("t5go2", 32'hE000_0012, 32'h4C, 1'b1, 32'h48);
        stall_f = 1'b1; stall_d = 1'b1; flush_d = 1'b1;
        step(); chk_fd("t5fl", NOP, 32'h0, 1'b0, 32'h48);
        stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;

        // 6: async reset while in WAIT_REDIR
        imem_ready = 1'b0; pc_src = 1'b1; branch_target = 32'h300;
        step(); chk_fd("t6wr", NOP, 32'h0, 1'b0, 32'h48);
        pc_src = 1'b0;
        #2; rst = 1'b1;
        #1;
        chk("t6.req", {31'b0, imem_req}, 32'd0);
        chk_fd("t6rst", NOP, 32'h0, 1'b0, 32'h0);
        chk("t6.fetch_cnt", fetch_cnt, 32'd0);
        chk("t6.bubble_cnt", bubble_cnt, 32'd0);
        #1; rst = 1'b0; imem_ready = 1'b1;
        step(); chk_fd("t6post", 32'hE000_0001, 32'h08, 1'b1, 32'h04);

        `ifdef FETCH_PERF_CNT_EN
        chk("end.fetch_cnt", fetch_cnt, 32'd1);
        `else
        chk("end.fetch_cnt", fetch_cnt, 32'd0);
        chk("end.bubble_cnt", bubble_cnt, 32'd0);
        `endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the decode stage; owns the architectural PC and the fetch/decode pipeline register.
- Drives the instruction-memory address and waits on a ready handshake.
- Applies branch redirects from execute and the hazard unit's stall/flush.
- Presents inst_d / pc_d / valid_d to decode. pc_d follows the R15-read convention: fetch address + 8.

Parameters:
N, 32, datapath/address width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0000, instruction word driven on inst_d for bubbles

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
stall_f  input  1  hold PC (hazard unit)
stall_d  input  1  hold F/D register (hazard unit)
flush_d  input  1  replace F/D contents with bubble
pc_src  input  1  branch/jump taken, single-cycle pulse from execute
branch_target  input  N  redirect address, valid when pc_src=1
imem_addr  output  N  instruction-memory address (= pc_f)
imem_req  output  1  fetch request
imem_rdata  input  N  instruction word, valid when imem_ready=1
imem_ready  input  1  memory has data for imem_addr this cycle
inst_d  output  N  instruction to decode
pc_d  output  N  fetch address of inst_d + 8
valid_d  output  1  inst_d is a real instruction (0 = bubble)
fetch_cnt  output  32  instructions delivered (optional feature)
bubble_cnt  output  32  bubble cycles inserted (optional feature)

Behaviour:
- Reset (asynchronous, immediate):
  - pc_f=RESET_PC, state=FETCH, pending_target=0.
  - inst_d=NOP_INST, pc_d=0, valid_d=0, imem_req=0 while rst is high.
- imem_req=1 whenever rst=0. imem_addr=pc_f, combinational.
- Handshake: imem_addr is held stable while imem_ready=0. A word is consumed only in a cycle with imem_req=1 and imem_ready=1.
- States:
  - FETCH: normal operation.
  - WAIT: memory not ready.
  - WAIT_REDIR: memory not ready, redirect pending.
- Next-PC priority per clock edge: rst > memory-wait hold > pc_src > stall_f > pc_f+4 (wraps modulo 2^N).
- FETCH:
  - imem_ready=1 and stall_f=0: pc_f <= pc_src ? branch_target : pc_f+4.
  - imem_ready=0: stay at pc_f, go to WAIT. If pc_src=1 the same cycle, latch pending_target=branch_target and go to WAIT_REDIR.
- WAIT:
  - imem_ready=0 and pc_src=1: latch target, go to WAIT_REDIR.
  - imem_ready=1: behave exactly as FETCH this cycle, then return to FETCH.
- WAIT_REDIR:
  - Hold pc_f until imem_ready=1; the returned word is discarded (F/D gets a bubble).
  - Then pc_f <= pending_target, go to FETCH.
  - A further pc_src in this state overwrites pending_target (last redirect wins).
- F/D register update priority: flush_d or pc_src > stall_d > load.
  - Load with a consumed word (not discarded): inst_d=imem_rdata, pc_d=pc_f+8, valid_d=1.
  - Bubble: inst_d=NOP_INST, pc_d=0, valid_d=0.
  - stall_d=1 and no flush: all three F/D outputs are held.
  - Load with no consumed word (imem_ready=0, or discard in WAIT_REDIR): bubble.
- stall_f=1 with stall_d=0 and no flush: F/D loads a bubble.
- Latency: word returned with imem_ready=1 at edge k appears on inst_d after edge k. Zero-wait-state memory gives one instruction per cycle.
- Branch penalty:
  - The fetch-stage word in the pc_src cycle is squashed (bubble).
  - The first target instruction reaches decode two edges after pc_src with zero-wait memory.
- Reset mid-wait: the outstanding request is abandoned and the pending redirect is cleared.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined:
  - fetch_cnt increments on every edge where F/D loads with valid_d=1.
  - bubble_cnt increments on every edge where F/D loads a bubble; stall_d holds are not counted.
  - Both reset to 0 and wrap at 2^32.
- Not defined: counters are absent and both outputs are tied to 0.

Test Plan:
1. Reset release, zero-wait memory returning {0xE000_0001, 0xE000_0002, ...} -> imem_addr 0, 4, 8 on successive cycles; inst_d=0xE000_0001 with pc_d=8 after the first edge, valid_d=1 every cycle.
2. imem_ready low 3 cycles at addr 0x10 -> imem_addr stays 0x10; three bubbles (valid_d=0, inst_d=NOP_INST); then inst at 0x10 with pc_d=0x18.
3. pc_src=1, branch_target=0x100 at pc_f=0x20, zero-wait -> next imem_addr=0x100; F/D bubble; inst from 0x100 with pc_d=0x108 one edge later.
4. pc_src=1, target 0x200, while in WAIT at 0x30, ready returns 2 cycles later -> word for 0x30 discarded (valid_d=0); imem_addr then 0x200.
5. stall_d=1 and stall_f=1 for 2 cycles at pc_f=0x40 -> inst_d/pc_d/valid_d and imem_addr unchanged; the stall_f-only case inserts a bubble; flush_d with stall_d gives a bubble.
6. rst asserted mid-WAIT_REDIR -> outputs are reset values immediately with no clock edge; pc_f=RESET_PC; pending redirect lost. With FETCH_PERF_CNT_EN, counters read 0.
